stm_focus_gen: RTL

- Parametrised successor to the single-focus STM phase engine: computes one 8-bit phase per transducer from one focal point.
- Generalises coordinate width, transducer count, BRAM read latency and transducer Z.
- Replaces the divide-by-sound-speed with a multiply by a precomputed wavenumber, using an in-block pipelined integer square root.
- Sits between the STM focus BRAM and the pulse-width/phase output stage; issues one transducer per cycle; signals completion with DONE.

---
 rtl/stm_focus_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stm_focus_gen.sv
// stm_focus_gen: streams one 8-bit phase per transducer for a single focal point.
module stm_focus_gen #(
  parameter int DEPTH = 249,
  parameter int COORD_W = 18,
  parameter int BRAM_LAT = 2,
  parameter int WN_W = 16,
  parameter int WN_FRAC = 14,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [12:0]        IDX,
  output logic [12:0]        FOCUS_IDX,
  input  logic [COORD_W-1:0] FOCUS_X,
  input  logic [COORD_W-1:0] FOCUS_Y,
  input  logic [COORD_W-1:0] FOCUS_Z,
  input  logic [7:0]         FOCUS_INTENSITY,
  output logic [AW-1:0]      TR_ADDR,
  input  logic [COORD_W-1:0] TR_X,
  input  logic [COORD_W-1:0] TR_Y,
  input  logic [COORD_W-1:0] TR_Z,
  input  logic [WN_W-1:0]    WAVENUM,
  input  logic [7:0]         PHASE_OFFSET,
  output logic               BUSY,
  output logic               DONE,
  output logic               DOUT_VALID,
  output logic [AW-1:0]      DOUT_ADDR,
  output logic [7:0]         PHASE,
  output logic [7:0]         INTENSITY
);
  localparam int C1 = COORD_W + 1;
  localparam int SW = 2 * C1;
  localparam int SQ_W = COORD_W + 2;
  localparam int D2_W = 2 * SQ_W;
  localparam int R_W = SQ_W + 2;
  localparam int P_W = SQ_W + WN_W;
  localparam int LAT = 5 + SQ_W;
  localparam int CW = $clog2(BRAM_LAT + 2);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, FIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] fcnt;
  logic fetch_done, last_tr;
  logic [COORD_W-1:0] fx, fy, fz;
  logic signed [C1-1:0] dx, dy, dz;
  logic [SW-1:0] sqx, sqy, sqz;
  logic [D2_W-1:0] sq_d [SQ_W];
  logic [R_W-1:0] sq_r [SQ_W];
  logic [SQ_W-1:0] sq_q [SQ_W+1];
  logic [P_W-1:0] prod;
  logic [LAT-2:0] sr;
  logic [AW-1:0] tag [LAT-1];

  assign fetch_done = state == FETCH && fcnt == CW'(BRAM_LAT);
  assign last_tr = TR_ADDR == AW'(DEPTH - 1);
  assign BUSY = state != IDLE;
  assign DONE = state == FIN;

  always_comb begin
    nxt = state == IDLE  ? (START ? FETCH : IDLE)
        : state == FETCH ? (fetch_done ? ISSUE : FETCH)
        : state == ISSUE ? (last_tr ? DRAIN : ISSUE)
        : state == DRAIN ? (|sr ? DRAIN : FIN)
        : IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      fcnt <= '0;
      FOCUS_IDX <= '0;
      TR_ADDR <= '0;
      INTENSITY <= '0;
      sr <= '0;
      DOUT_VALID <= 1'b0;
      DOUT_ADDR <= '0;
      PHASE <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && START) FOCUS_IDX <= IDX;
      fcnt <= state == FETCH ? fcnt + 1'b1 : '0;
      TR_ADDR <= state == ISSUE && !last_tr ? TR_ADDR + 1'b1 : state == FIN ? '0 : TR_ADDR;
      if (fetch_done) INTENSITY <= FOCUS_INTENSITY;
      sr <= {sr[LAT-3:0], state == ISSUE};
      DOUT_VALID <= sr[LAT-2];
      if (sr[LAT-2]) begin
        DOUT_ADDR <= tag[LAT-2];
        PHASE <= 8'(prod >> WN_FRAC) + PHASE_OFFSET;
      end
    end
  end

  // Datapath carries no reset; only the valid shift register qualifies it.
  always_ff @(posedge CLK) begin
    if (fetch_done) {fx, fy, fz} <= {FOCUS_X, FOCUS_Y, FOCUS_Z};
    dx <= {fx[COORD_W-1], fx} - {TR_X[COORD_W-1], TR_X};
    dy <= {fy[COORD_W-1], fy} - {TR_Y[COORD_W-1], TR_Y};
    dz <= {fz[COORD_W-1], fz} - {TR_Z[COORD_W-1], TR_Z};
    sqx <= SW'(dx) * SW'(dx);
    sqy <= SW'(dy) * SW'(dy);
    sqz <= SW'(dz) * SW'(dz);
    sq_d[0] <= D2_W'(sqx) + D2_W'(sqy) + D2_W'(sqz);
    sq_r[0] <= '0;
    sq_q[0] <= '0;
    prod <= P_W'(sq_q[SQ_W]) * P_W'(WAVENUM);
    tag[0] <= TR_ADDR;
    for (int i = 1; i < LAT - 1; i++) tag[i] <= tag[i-1];
  end

  // Restoring square root: each stage brings down two radicand bits, yields one root bit.
  for (genvar s = 1; s <= SQ_W; s++) begin : g_sq
    logic [R_W+1:0] t, trial;
    logic ge;
    assign t = {sq_r[s-1], sq_d[s-1][D2_W-1 -: 2]};
    assign trial = {2'b00, sq_q[s-1], 2'b01};
    assign ge = t >= trial;
    always_ff @(posedge CLK) sq_q[s] <= {sq_q[s-1][SQ_W-2:0], ge};
    if (s < SQ_W) begin : g_rem
      always_ff @(posedge CLK) begin
        sq_r[s] <= R_W'(ge ? t - trial : t);
        sq_d[s] <= sq_d[s-1] << 2;
      end
    end
  end
endmodule
